// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: requests a byte from instruction
// memory, presents it with a valid/ready handshake, and stops on HALT_OP.
module fetch_unit #(
    parameter int          PC_W    = 4,
    parameter logic [3:0]  HALT_OP = 4'b1111,
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_re,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [7:0]       imem_data,
    output logic [7:0]       instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic             imem_re_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [7:0]       instr_q;
    logic             valid_q;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             is_halt;

    // pc wraps naturally at 2**PC_W; the counter sticks at its maximum
    assign pc_d    = pc_q + PC_W'(1);
    assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign is_halt = (instr_q[7:4] == HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            imem_re_q <= 1'b0;
            pc_q      <= '0;
            instr_q   <= 8'h00;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        imem_re_q <= 1'b1;
                    end
                end
                REQ: begin
                    state_q   <= WAIT;
                    imem_re_q <= 1'b0;
                end
                WAIT: begin
                    state_q <= ISSUE;
                    instr_q <= imem_data;
                    valid_q <= 1'b1;
                end
                ISSUE: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_d;
                        if (is_halt) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            imem_re_q <= 1'b1;
                            pc_q      <= pc_d;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q   <= IDLE;
                    imem_re_q <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_re     = imem_re_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       imem_re;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] pc;
    logic       halted;
    logic [7:0] instr_count;

    logic [7:0] mem [16];
    logic [7:0] prog [4];

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_re) imem_data <= mem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        imem_data   = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_cnt", 32'(instr_count), 32'h0);
        chk("rst_re", 32'(imem_re), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        tick();
        chk("idle_re", 32'(imem_re), 32'h0);

        // first fetch and its latency
        mem[0] = 8'h05;
        mem[1] = 8'h12;
        mem[2] = 8'h33;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_re", 32'(imem_re), 32'h1);
        chk("c1_addr", 32'(imem_addr), 32'h0);
        tick();
        chk("c2_re", 32'(imem_re), 32'h0);
        chk("c2_valid", 32'(instr_valid), 32'h0);
        tick();
        chk("c3_instr", 32'(instr), 32'h05);
        chk("c3_valid", 32'(instr_valid), 32'h1);
        tick();
        chk("c4_pc", 32'(pc), 32'h1);
        chk("c4_valid", 32'(instr_valid), 32'h0);
        chk("c4_cnt", 32'(instr_count), 32'h1);
        chk("c4_re", 32'(imem_re), 32'h1);

        // back-pressure, with start held high in WAIT/ISSUE
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        chk("bp_wait_valid", 32'(instr_valid), 32'h0);
        tick();
        chk("bp_instr", 32'(instr), 32'h12);
        chk("bp_valid", 32'(instr_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(instr_valid), 32'h1);
            chk("bp_hold_instr", 32'(instr), 32'h12);
            chk("bp_hold_pc", 32'(pc), 32'h1);
            chk("bp_hold_re", 32'(imem_re), 32'h0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp_hs_pc", 32'(pc), 32'h2);
        chk("bp_hs_cnt", 32'(instr_count), 32'h2);
        chk("bp_hs_valid", 32'(instr_valid), 32'h0);
        chk("bp_hs_re", 32'(imem_re), 32'h1);
        tick();
        tick();
        start = 1'b0;
        chk("bp_next_instr", 32'(instr), 32'h33);
        chk("bp_next_valid", 32'(instr_valid), 32'h1);
        chk("bp_one_hs_cnt", 32'(instr_count), 32'h2);
        chk("bp_next_pc", 32'(pc), 32'h2);

        // program ending in HALT_OP
        do_reset();
        chk("p_rst_pc", 32'(pc), 32'h0);
        prog[0] = 8'h00;
        prog[1] = 8'h21;
        prog[2] = 8'h43;
        prog[3] = 8'hF0;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            chk("p_instr", 32'(instr), 32'(prog[i]));
            chk("p_valid", 32'(instr_valid), 32'h1);
            chk("p_pc", 32'(pc), 32'(i));
            tick();
            chk("p_halted", 32'(halted), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("p_end_pc", 32'(pc), 32'h3);
        chk("p_end_cnt", 32'(instr_count), 32'h4);
        chk("p_end_valid", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            start = (i % 2 == 0);
            tick();
            chk("h_re", 32'(imem_re), 32'h0);
            chk("h_halted", 32'(halted), 32'h1);
            chk("h_valid", 32'(instr_valid), 32'h0);
        end
        start = 1'b0;

        // reset colliding with a handshake
        do_reset();
        mem[0] = 8'h05;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rh_valid_pre", 32'(instr_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_cnt", 32'(instr_count), 32'h0);
        chk("rh_pc", 32'(pc), 32'h0);
        chk("rh_valid", 32'(instr_valid), 32'h0);
        chk("rh_halted", 32'(halted), 32'h0);
        chk("rh_re", 32'(imem_re), 32'h0);
        tick();
        chk("rh_idle_re", 32'(imem_re), 32'h0);

        // pc wrap and counter saturation
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            tick();
            tick();
            if (n == 16) chk("w_instr15", 32'(instr), 32'h1F);
            tick();
            if (n == 16) begin
                chk("w_pc", 32'(pc), 32'h0);
                chk("w_addr", 32'(imem_addr), 32'h0);
                chk("w_re", 32'(imem_re), 32'h1);
            end
            if (n == 254) chk("s_cnt254", 32'(instr_count), 32'd254);
            if (n == 255) chk("s_cnt255", 32'(instr_count), 32'd255);
        end
        chk("s_cnt_sat", 32'(instr_count), 32'd255);
        chk("s_pc", 32'(pc), 32'(260 % 16));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 4, program counter width; instruction memory depth is 2**PC_W.
REQ-002 Parameter HALT_OP, default 4'b1111, opcode (instr[7:4]) that stops fetching.
REQ-003 Parameter CNT_W, default 8, width of the issued-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  pulse or level; begins fetching from the current PC when in IDLE.
REQ-007 imem_re  output  1  instruction memory read strobe.
REQ-008 imem_addr  output  PC_W  instruction memory read address.
REQ-009 imem_data  input  8  instruction memory read data, valid exactly one cycle after imem_re.
REQ-010 instr  output  8  instruction presented to the decoder.
REQ-011 instr_valid  output  1  instr holds a fetched, not-yet-accepted instruction.
REQ-012 instr_ready  input  1  the decode/execute stage accepts instr this cycle.
REQ-013 pc  output  PC_W  address of the instruction currently being fetched or presented.
REQ-014 halted  output  1  the HALT_OP instruction has been accepted; fetching has stopped.
REQ-015 instr_count  output  CNT_W  number of instructions accepted since reset, saturating.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, REQ, WAIT, ISSUE and HALT.
REQ-017 IDLE: all strobes low; start=1 -> REQ next cycle; start=0 -> stay in IDLE.
REQ-018 REQ: imem_re=1 and imem_addr=pc for exactly one cycle; -> WAIT unconditionally.
REQ-019 WAIT: imem_re=0; imem_data is registered into instr at the end of the cycle; -> ISSUE.
REQ-020 ISSUE: instr_valid=1; the handshake completes on a cycle where instr_valid=1 and instr_ready=1.
REQ-021 While instr_valid=1 and instr_ready=0, instr and pc SHALL hold stable, with no memory read.
REQ-022 On handshake with instr[7:4] != HALT_OP: pc <= pc+1 modulo 2**PC_W, so pc at maximum wraps to 0; -> REQ.
REQ-023 On handshake with instr[7:4] == HALT_OP: pc unchanged; -> HALT.
REQ-024 HALT: halted=1, instr_valid=0, imem_re=0; start is ignored; exit only via rst.
REQ-025 instr_valid SHALL deassert in the cycle after the handshake; there is no back-to-back issue, so minimum issue spacing is 3 cycles.
REQ-026 instr_count SHALL increment by 1 on every handshake, including the HALT_OP handshake, and saturate at 2**CNT_W-1.
REQ-027 start asserted in any state other than IDLE SHALL have no effect.
REQ-028 imem_addr SHALL equal pc in all states; imem_re is the only read qualifier.
REQ-029 Outputs instr, instr_valid, halted, pc and instr_count SHALL be driven from registers, with no combinational path from instr_ready or imem_data.

Reset
REQ-030 rst=1 at a rising edge, in any state including mid-handshake, SHALL force the FSM to IDLE, pc=0, instr=8'h00, instr_valid=0, imem_re=0, halted=0 and instr_count=0 in the following cycle.
REQ-031 rst has priority over start, instr_ready and every FSM transition in the same cycle.

Verification
REQ-032 Reset, then pulse start with imem[0]=8'h05, ready=1 -> imem_re in cycle 1 with addr 0; instr=8'h05 and valid in cycle 3; pc=1 and valid=0 in cycle 4; instr_count=1.
REQ-033 Hold ready=0 for 5 cycles during ISSUE -> instr_valid stays 1, instr and pc stay unchanged, and no imem_re pulse occurs; raising ready completes exactly one handshake.
REQ-034 Program 8'h00, 8'h21, 8'h43, 8'hF0 with ready=1 -> 4 instructions are issued in order, halted=1 after the 4th handshake, pc=3, instr_count=4, and later start pulses cause no imem_re.
REQ-035 PC_W=4, memory holding no HALT_OP, ready=1 -> after the handshake at pc=15, the next read is at addr 0; instr_count saturates at 255 and does not wrap.
REQ-036 Assert rst while instr_valid=1 and instr_ready=1 in the same cycle -> instr_count is not incremented, and the next cycle shows IDLE with pc=0, valid=0 and halted=0.
REQ-037 Assert start in WAIT and in ISSUE -> the state sequence and pc are identical to a run with start held low in those cycles.
